wib_fetch: RTL
==============

WIB_FETCH -- requirements
Module: wib_fetch

Interface
REQ-001 Parameter RD_LAT, default 1: read latency of the downstream weight/bias buffer, in cycles; legal values are 1 (unregistered output) and 2 (registered output).
REQ-002 Parameter FIFO_DEPTH, default 4: depth of the internal return FIFO; SHALL be at least RD_LAT+2 and a power of 2.
REQ-003 Design SHALL use one clock; reset is synchronous and active-high.
REQ-004 i_clk  input  1  sole clock; all logic on its rising edge.
REQ-005 i_rst  input  1  synchronous, active-high reset.
REQ-006 i_start  input  1  one-cycle pulse that launches a fetch job.
REQ-007 i_base_addr  input  10  first word address of the job.
REQ-008 i_len  input  11  number of words in the job; legal range 0..1024.
REQ-009 o_busy  output  1  high while a job is in progress.
REQ-010 o_done  output  1  one-cycle pulse marking job completion.
REQ-011 o_wib_raddr  output  10  read address, to i_wib_raddr of the buffer.
REQ-012 o_wib_rd_en  output  1  read enable, to i_wib_rd_en of the buffer.
REQ-013 i_wib_rdat  input  19  buffer read data, from o_wib_rdat.
REQ-014 o_wt_dat  output  19  weight/bias word presented to the PE array.
REQ-015 o_wt_vld  output  1  o_wt_dat is valid.
REQ-016 i_wt_rdy  input  1  PE array accepts the word.

Function
REQ-017 A word SHALL transfer to the PE array in every cycle where o_wt_vld and i_wt_rdy are both high.
REQ-018 Once o_wt_vld is high, o_wt_vld and o_wt_dat SHALL hold stable until the word transfers.
REQ-019 The FSM SHALL have three states: IDLE, FETCH and DRAIN.
- IDLE -> FETCH on i_start with i_len != 0.
- FETCH -> DRAIN after the read for the last address is issued.
- DRAIN -> IDLE when the last word transfers.
REQ-020 When i_start arrives with i_len == 0, the block SHALL stay in IDLE and pulse o_done on the next cycle.
REQ-021 When i_start arrives, the block SHALL latch i_base_addr and i_len.
REQ-022 i_start SHALL be ignored whenever o_busy is high.
REQ-023 o_busy SHALL be high in FETCH and DRAIN, and low in IDLE.
REQ-024 o_done SHALL pulse for one cycle, in the same cycle the block returns to IDLE.
REQ-025 In FETCH, o_wib_rd_en SHALL be asserted only when (FIFO occupancy + reads in flight) < FIFO_DEPTH.
REQ-026 o_wib_raddr SHALL start at the base address and increment by 1 per issued read, wrapping from 1023 to 0.
REQ-027 Read data SHALL be captured into the FIFO exactly RD_LAT cycles after the matching o_wib_rd_en, tracked by an internal RD_LAT-deep valid shift register.
REQ-028 The block SHALL NOT use the buffer's own read-valid signal, because that signal is only correct when RD_LAT=1.
REQ-029 With i_wt_rdy held high and no stalls, the block SHALL sustain one word per cycle.
REQ-030 First-word latency SHALL be RD_LAT+2 cycles from i_start to o_wt_vld.
REQ-031 A FIFO push and pop in the same cycle SHALL leave occupancy unchanged.
REQ-032 The FIFO SHALL never overflow and never underflow.
REQ-033 Words SHALL reach the PE array in address order, with no loss and no duplication.

Reset
REQ-034 i_rst SHALL be sampled on the rising edge of i_clk only.
REQ-035 Reset values SHALL be:
- FSM in IDLE;
- o_busy, o_done, o_wib_rd_en and o_wt_vld all 0;
- o_wib_raddr and o_wt_dat both 0;
- FIFO empty and in-flight count 0.
REQ-036 Reset during a job SHALL abort the job: data still in flight is discarded, and o_done SHALL NOT pulse.

Configuration
REQ-037 The feature macro is WIB_FETCH_STALL_CNT_EN.
REQ-038 With WIB_FETCH_STALL_CNT_EN defined, the block SHALL add output o_stall_cnt (16 bits).
- It counts cycles in FETCH or DRAIN where o_wt_vld is high and i_wt_rdy is low.
- It saturates at 0xFFFF.
- It clears on i_rst and on each accepted i_start.
REQ-039 With WIB_FETCH_STALL_CNT_EN not defined, the port and counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-040 Shared package npu_pkg SHALL hold the constants WIB_AW=10, WIB_DW=19 and WIB_WORDS=1024, plus the FSM state typedef.
REQ-041 The return FIFO SHALL be a sub-module named wib_ret_fifo, parameterised by width and depth, exposing push, pop, full, empty and count.
REQ-042 The fetch FSM, address counter and latency shift register SHALL live in wib_fetch.

Verification
REQ-043 Base 0x010, len 8, i_wt_rdy=1, RD_LAT=1 -> o_wt_vld first high 3 cycles after start; 8 consecutive words from addresses 0x010..0x017; o_done pulses with the last transfer.
REQ-044 Base 0x3FE, len 4 -> words read from addresses 0x3FE, 0x3FF, 0x000, 0x001, in that order.
REQ-045 Len 16 with i_wt_rdy toggling 1,0,0,1 repeatedly -> o_wib_rd_en is never high while occupancy + in-flight = 4; all 16 words arrive in order; o_wt_dat holds stable while stalled.
REQ-046 RD_LAT=2 with a buffer that registers its output -> captured data matches the buffer contents (checked against a model), with no off-by-one shift.
REQ-047 Len 0 -> o_done on the next cycle, o_busy never high; a second i_start mid-job -> ignored, and the job length is unchanged.
REQ-048 i_rst asserted mid-job after 5 of 10 words -> the next cycle shows all outputs at reset values; a subsequent job of len 3 completes correctly; with WIB_FETCH_STALL_CNT_EN defined, o_stall_cnt equals the number of stalled cycles.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared NPU definitions: weight/bias buffer geometry and the fetch FSM
// state type used by wib_fetch.
package npu_pkg;

   localparam int WIB_AW    = 10;
   localparam int WIB_DW    = 19;
   localparam int WIB_WORDS = 1024;

   // Job length needs one bit more than the address so 1024 is representable.
   localparam int WIB_LW    = $clog2(WIB_WORDS) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/wib_ret_fifo.sv
// Return FIFO between the weight/bias buffer read port and the PE array.
// Synchronous FIFO with an explicit occupancy count; DEPTH must be a power
// of two. The head word is forced to zero while empty so the consumer never
// sees uninitialised storage.
module wib_ret_fifo
   import npu_pkg::*;
#(
   parameter int WIDTH = WIB_DW,
   parameter int DEPTH = 4
)
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // A push into a full FIFO or a pop from an empty one is dropped.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Storage write; pointers wrap naturally because DEPTH is a power of two.
   // NOTE: the storage array has no reset; validity is tracked by count alone.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointer and occupancy update; simultaneous push and pop keep count.
   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));
   assign dout  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/wib_fetch.sv
// Weight/bias fetch engine: streams a job of i_len words starting at
// i_base_addr out of the weight/bias buffer into the PE array.
// Reads are issued only when the return FIFO is guaranteed to have room for
// every outstanding read; returning data is captured RD_LAT cycles after
// each read by a local valid shift register, independent of any buffer
// valid signal.
// Optional feature: define WIB_FETCH_STALL_CNT_EN to add o_stall_cnt, a
// saturating count of cycles where a word was offered but not accepted.
module wib_fetch
   import npu_pkg::*;
#(
   parameter int RD_LAT     = 1,
   parameter int FIFO_DEPTH = 4
)
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [WIB_AW-1:0] i_base_addr,
   input  logic [WIB_LW-1:0] i_len,
   output logic              o_busy,
   output logic              o_done,
   output logic [WIB_AW-1:0] o_wib_raddr,
   output logic              o_wib_rd_en,
   input  logic [WIB_DW-1:0] i_wib_rdat,
   output logic [WIB_DW-1:0] o_wt_dat,
   output logic              o_wt_vld,
   input  logic              i_wt_rdy
`ifdef WIB_FETCH_STALL_CNT_EN
   ,
   output logic [15:0]       o_stall_cnt
`endif
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   fetch_state_t      state;
   fetch_state_t      state_nxt;
   logic [WIB_AW-1:0] raddr;
   logic [WIB_LW-1:0] rd_rem;
   logic [WIB_LW-1:0] xfer_rem;
   logic [RD_LAT-1:0] vld_sr;
   logic [CW-1:0]     inflight;
   logic [CW-1:0]     fifo_count;
   logic [CW:0]       occ_sum;
   logic              fifo_full;
   logic              fifo_empty;
   logic              issue_ok;
   logic              accept;
   logic              fire;
   logic              last_rd;
   logic              last_xfer;
   logic              zero_done;

   // Starts are only honoured from IDLE, which is exactly when o_busy is low.
   assign accept    = i_start && (state == IDLE);
   assign fire      = o_wt_vld && i_wt_rdy;
   assign last_rd   = o_wib_rd_en && (rd_rem == WIB_LW'(1));
   assign last_xfer = fire && (xfer_rem == WIB_LW'(1));

   // Count reads issued but not yet returned from the buffer.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         inflight = inflight + CW'(vld_sr[i]);
      end
   end

   // A new read is safe only if the FIFO can absorb it plus all reads in flight.
   assign occ_sum  = (CW+1)'(fifo_count) + (CW+1)'(inflight);
   assign issue_ok = (occ_sum < (CW+1)'(FIFO_DEPTH)) && !fifo_full;

   // FSM state register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept && (i_len != '0)) state_nxt = FETCH;
         FETCH:   if (last_rd)                 state_nxt = DRAIN;
         DRAIN:   if (last_xfer)               state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs; a reset in the completing cycle aborts the job silently.
   always_comb begin
      o_busy      = 1'b0;
      o_wib_rd_en = 1'b0;
      o_done      = 1'b0;
      unique case (state)
         IDLE: begin
            o_done = zero_done;
         end
         FETCH: begin
            o_busy      = 1'b1;
            o_wib_rd_en = issue_ok;
         end
         DRAIN: begin
            o_busy = 1'b1;
            o_done = last_xfer;
         end
         default: begin
            o_busy = 1'b0;
         end
      endcase
      if (i_rst) begin
         o_done = 1'b0;
      end
   end

   // Job bookkeeping: latch base/length on start, then count reads and transfers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         raddr     <= '0;
         rd_rem    <= '0;
         xfer_rem  <= '0;
         zero_done <= 1'b0;
      end else begin
         zero_done <= accept && (i_len == '0);
         if (accept) begin
            raddr    <= i_base_addr;
            rd_rem   <= i_len;
            xfer_rem <= i_len;
         end else begin
            if (o_wib_rd_en) begin
               raddr  <= raddr + WIB_AW'(1);
               rd_rem <= rd_rem - WIB_LW'(1);
            end
            if (fire) begin
               xfer_rem <= xfer_rem - WIB_LW'(1);
            end
         end
      end
   end

   assign o_wib_raddr = raddr;

   // Read-latency tracker: the oldest stage marks the cycle its data is valid.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         vld_sr <= '0;
      end else begin
         vld_sr[0] <= o_wib_rd_en;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_sr[i] <= vld_sr[i-1];
         end
      end
   end

   wib_ret_fifo #(
      .WIDTH (WIB_DW),
      .DEPTH (FIFO_DEPTH)
   ) u_ret_fifo (
      .clk   (i_clk),
      .rst   (i_rst),
      .push  (vld_sr[RD_LAT-1]),
      .din   (i_wib_rdat),
      .pop   (fire),
      .dout  (o_wt_dat),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign o_wt_vld = !fifo_empty;

`ifdef WIB_FETCH_STALL_CNT_EN
   // Saturating count of back-pressured cycles within the current job.
   always_ff @(posedge i_clk) begin
      if (i_rst || accept) begin
         o_stall_cnt <= '0;
      end else if (o_busy && o_wt_vld && !i_wt_rdy && (o_stall_cnt != 16'hFFFF)) begin
         o_stall_cnt <= o_stall_cnt + 16'd1;
      end
   end
`endif

endmodule
